fifo_drain_serializer: RTL and testbench

- Read-side consumer for the 140-bit clock-crossing FIFO; runs entirely in the `clk_out` domain.
- Pops one word at a time using the FIFO's `fifo_r_enable`/`fifo_empty` pair and captures `data_from_fifo`.
- Emits each word MSB-first as `NUM_BEATS` beats of `OUT_W` bits on a valid/ready stream, flagging the final beat.
- Holds off after each pop for the FIFO's synchronized-empty latency, so a stale `fifo_empty` never triggers a phantom pop.

---
 rtl/fifo_drain_serializer.sv | 123 ++++++++++++
 tb/tb_fifo_drain_serializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_serializer.sv
// Pops 140-bit words from the read side of a clock-crossing FIFO and emits each one MSB-first as NUM_BEATS valid/ready beats.
// First beat appears 3 cycles after IDLE sees non-empty; m_ready low freezes the current beat, and no new pop happens until the word has drained.
module fifo_drain_serializer #(
  parameter int WIDTH     = 140,
  parameter int OUT_W     = 20,
  parameter int EMPTY_LAT = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] data_from_fifo,
  output logic             fifo_r_enable,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] words_read
);

  localparam int NUM_BEATS = WIDTH / OUT_W;
  localparam int BC_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int HO_W      = $clog2(EMPTY_LAT + 1);

  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NUM_BEATS - 1);
  localparam logic [HO_W-1:0] HOLD_INIT = HO_W'(EMPTY_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BC_W-1:0]  beat_cnt;
  logic [HO_W-1:0]  holdoff;
  logic             pop_ok;
  logic             beat_fire;
  logic             last_beat;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fifo_r_enable = 1'b0;
    m_valid       = 1'b0;
    case (state)
      IDLE: begin
        if ((holdoff == '0) && !fifo_empty) begin
          state_nxt = RD;
        end
      end
      RD: begin
        fifo_r_enable = 1'b1;
        // An empty flag here means the FIFO ignored the request.
        state_nxt = fifo_empty ? IDLE : CAP;
      end
      CAP: begin
        state_nxt = SEND;
      end
      SEND: begin
        m_valid = 1'b1;
        if (m_ready && last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign m_last    = m_valid && last_beat;
  assign m_data    = shreg[WIDTH-1 -: OUT_W];
  assign busy      = (state != IDLE);
  assign pop_ok    = (state == RD) && !fifo_empty;
  assign beat_fire = m_valid && m_ready;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      beat_cnt <= '0;
    end else if (state == CAP) begin
      shreg    <= data_from_fifo;
      beat_cnt <= '0;
    end else if (beat_fire) begin
      shreg    <= shreg << OUT_W;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // The FIFO's empty flag trails a pop by EMPTY_LAT cycles; blocking new
  // reads for that long keeps a stale "not empty" from causing a phantom pop.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      holdoff <= '0;
    end else if (pop_ok) begin
      holdoff <= HOLD_INIT;
    end else if (holdoff != '0) begin
      holdoff <= holdoff - 1'b1;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      words_read <= '0;
    end else if (pop_ok) begin
      words_read <= words_read + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: lagging-empty FIFO model feeding the DUT, beat scoreboard, plus a narrow-counter instance for wrap.
module tb_fifo_drain_serializer;

  localparam int WIDTH = 140;
  localparam int OUT_W = 20;
  localparam int NB    = 7;

  logic             clk_out = 1'b0;
  logic             rst_n;
  logic             fifo_empty;
  logic [WIDTH-1:0] data_from_fifo = '0;
  logic             fifo_r_enable;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic [15:0]      words_read;

  logic             empty2;
  logic [WIDTH-1:0] data2;
  logic             ren2;
  logic [OUT_W-1:0] mdata2;
  logic             mvalid2;
  logic             mlast2;
  logic             busy2;
  logic [3:0]       wr2;

  always #5 clk_out = ~clk_out;

  fifo_drain_serializer #(.WIDTH(WIDTH), .OUT_W(OUT_W), .EMPTY_LAT(3), .CNT_W(16)) dut (
    .clk_out(clk_out), .rst_n(rst_n), .fifo_empty(fifo_empty), .data_from_fifo(data_from_fifo),
    .fifo_r_enable(fifo_r_enable), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .words_read(words_read)
  );

  fifo_drain_serializer #(.WIDTH(WIDTH), .OUT_W(OUT_W), .EMPTY_LAT(3), .CNT_W(4)) dut_wrap (
    .clk_out(clk_out), .rst_n(rst_n), .fifo_empty(empty2), .data_from_fifo(data2),
    .fifo_r_enable(ren2), .m_data(mdata2), .m_valid(mvalid2), .m_last(mlast2),
    .m_ready(1'b1), .busy(busy2), .words_read(wr2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // FIFO model: pops on r_enable && !empty, data valid next cycle, empty lags by 3 edges.
  logic [WIDTH-1:0] fq[$];
  logic [20:0]      exp_q[$];
  logic [2:0]       empty_pipe = 3'b111;
  logic             ovr = 1'b0;
  logic             ovr_val = 1'b1;
  int               cyc = 0;
  int               phantom = 0;

  assign fifo_empty = ovr ? ovr_val : empty_pipe[2];

  function automatic logic [WIDTH-1:0] make_word(input logic [19:0] base);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NB; i++) w[WIDTH-1-OUT_W*i -: OUT_W] = base + 20'(i + 1);
    return w;
  endfunction

  assign data2 = make_word(20'h55550);

  task automatic push_word(input logic [19:0] base);
    fq.push_back(make_word(base));
    for (int i = 0; i < NB; i++) exp_q.push_back({1'(i == NB - 1), 20'(base + 20'(i + 1))});
  endtask

  initial begin
    forever begin
      @(posedge clk_out);
      cyc++;
      if (fifo_r_enable && !fifo_empty) begin
        if (fq.size() == 0) phantom++;
        else data_from_fifo <= fq.pop_front();
      end
      empty_pipe <= {empty_pipe[1:0], (fq.size() == 0)};
    end
  end

  int rdy_mode = 0;
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk_out);
      #1;
      k++;
      m_ready = (rdy_mode == 0) || (k % 3 == 0);
    end
  end

  // Monitor samples on the falling edge, away from the DUT's active edge.
  int ren_cnt = 0, hs_cnt = 0, vld_cnt = 0, last_cnt = 0, pops2 = 0, b2 = 0;
  int pop_cyc[$];
  bit lat_arm = 0;
  int lat_start = -1, lat_valid = -1;

  initial begin
    forever begin
      @(negedge clk_out);
      if (rst_n) begin
        if (fifo_r_enable) ren_cnt++;
        if (fifo_r_enable && !fifo_empty) pop_cyc.push_back(cyc);
        if (lat_arm && lat_start < 0 && !fifo_empty && !busy) lat_start = cyc;
        if (lat_arm && lat_valid < 0 && m_valid) lat_valid = cyc;
        if (m_valid) begin
          vld_cnt++;
          chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("beat_data", 64'(m_data), 64'(exp_q[0][19:0]));
            chk("beat_last", 64'(m_last), 64'(exp_q[0][20]));
            if (m_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
              if (m_last) last_cnt++;
            end
          end
        end else if (m_last) begin
          chk("last_without_valid", 64'(m_last), 64'd0);
        end
        if (ren2 && !empty2) pops2++;
        if (mvalid2) begin
          chk("wrap_beat_data", 64'(mdata2), 64'(20'h55551 + 20'(b2)));
          b2 = mlast2 ? 0 : b2 + 1;
        end else if (mlast2) begin
          chk("wrap_last_without_valid", 64'(mlast2), 64'd0);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(fq.size() == 0 && exp_q.size() == 0 && !busy && fifo_empty)) begin
      @(posedge clk_out);
      #1;
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
    repeat (3) @(posedge clk_out);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_ren, b_hs, b_vld, b_last, n;
    bit seen15;
    rst_n  = 1'b0;
    empty2 = 1'b1;
    repeat (3) @(posedge clk_out);
    #1;
    chk("rst_r_enable", 64'(fifo_r_enable), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_words_read", 64'(words_read), 64'd0);
    chk("rst_wr2", 64'(wr2), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_out);
    #1;

    // Single word, full rate; the empty flag stays stale for a while after the pop.
    b_ren = ren_cnt; b_vld = vld_cnt; b_last = last_cnt;
    push_word(20'hA0000);
    drain(200);
    chk("single_pops", 64'(ren_cnt - b_ren), 64'd1);
    chk("single_valid_cycles", 64'(vld_cnt - b_vld), 64'd7);
    chk("single_last_count", 64'(last_cnt - b_last), 64'd1);
    chk("single_words_read", 64'(words_read), 64'd1);
    chk("single_busy_low", 64'(busy), 64'd0);
    chk("single_phantom", 64'(phantom), 64'd0);

    // Backpressure: ready high one cycle in three.
    rdy_mode = 1;
    b_ren = ren_cnt; b_hs = hs_cnt; b_last = last_cnt; b_vld = vld_cnt;
    push_word(20'hA0000);
    drain(300);
    rdy_mode = 0;
    chk("bp_pops", 64'(ren_cnt - b_ren), 64'd1);
    chk("bp_handshakes", 64'(hs_cnt - b_hs), 64'd7);
    chk("bp_last_count", 64'(last_cnt - b_last), 64'd1);
    chk("bp_stalled", 64'((vld_cnt - b_vld) > 7), 64'd1);
    chk("bp_words_read", 64'(words_read), 64'd2);

    // Empty rises while in RD: request dropped, nothing captured.
    b_ren = ren_cnt; b_vld = vld_cnt;
    ovr = 1'b1; ovr_val = 1'b1;
    @(posedge clk_out); #1;
    ovr_val = 1'b0;
    @(posedge clk_out); #1;
    chk("erd_in_rd", 64'(fifo_r_enable), 64'd1);
    ovr_val = 1'b1;
    @(posedge clk_out); #1;
    chk("erd_back_idle", 64'(busy), 64'd0);
    repeat (5) @(posedge clk_out);
    #1;
    chk("erd_words_read", 64'(words_read), 64'd2);
    chk("erd_no_valid", 64'(vld_cnt - b_vld), 64'd0);
    chk("erd_one_request", 64'(ren_cnt - b_ren), 64'd1);
    ovr = 1'b0;
    repeat (2) @(posedge clk_out);
    #1;

    // Back-to-back: four words queued together.
    b_hs = hs_cnt; b_last = last_cnt;
    pop_cyc.delete();
    lat_start = -1; lat_valid = -1; lat_arm = 1;
    push_word(20'hB0000);
    push_word(20'hC0000);
    push_word(20'hD0000);
    push_word(20'hE0000);
    drain(400);
    lat_arm = 0;
    chk("b2b_pop_count", 64'(pop_cyc.size()), 64'd4);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("b2b_pop_spacing", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd10);
    chk("b2b_first_latency", 64'(lat_valid - lat_start), 64'd3);
    chk("b2b_handshakes", 64'(hs_cnt - b_hs), 64'd28);
    chk("b2b_last_count", 64'(last_cnt - b_last), 64'd4);
    chk("b2b_words_read", 64'(words_read), 64'd6);
    chk("b2b_phantom", 64'(phantom), 64'd0);

    // Counter wrap on the 4-bit instance with a never-empty source.
    seen15 = 0;
    n = 0;
    empty2 = 1'b0;
    while (n < 600 && pops2 < 16) begin
      @(posedge clk_out); #1;
      n++;
      if (pops2 == 15 && !seen15) begin
        seen15 = 1;
        chk("wrap_at_max", 64'(wr2), 64'hF);
      end
    end
    empty2 = 1'b1;
    chk("wrap_in_budget", 64'(pops2 >= 16), 64'd1);
    repeat (20) @(posedge clk_out);
    #1;
    chk("wrap_pops", 64'(pops2), 64'd16);
    chk("wrap_to_zero", 64'(wr2), 64'd0);
    chk("wrap_idle", 64'(busy2), 64'd0);

    // Reset during beat 3 discards the word; the pop is not replayed.
    b_hs = hs_cnt;
    push_word(20'hF0000);
    n = 0;
    while (n < 200 && !((hs_cnt - b_hs) == 2 && m_valid)) begin
      @(posedge clk_out); #1;
      n++;
    end
    chk("midrst_reached_beat3", 64'(n < 200), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_r_enable", 64'(fifo_r_enable), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_last", 64'(m_last), 64'd0);
    chk("midrst_m_data", 64'(m_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_words_read", 64'(words_read), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_out);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_out);
    #1;
    b_ren = ren_cnt; b_last = last_cnt;
    push_word(20'h12340);
    drain(200);
    chk("post_rst_pops", 64'(ren_cnt - b_ren), 64'd1);
    chk("post_rst_last_count", 64'(last_cnt - b_last), 64'd1);
    chk("post_rst_words_read", 64'(words_read), 64'd1);
    chk("post_rst_phantom", 64'(phantom), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
